// File: rtl/mac_stream_driver.sv
// mac_stream_driver: host-side driver for the MAC accelerator pins.
// Queues operand frames, clears the accelerator, streams pairs, returns the sum.

module mac_stream_driver #(
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_last,
    output logic       mac_rst,
    output logic [7:0] mac_a,
    output logic [7:0] mac_b,
    input  logic [7:0] mac_result,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic [7:0] res_count,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(LAT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Operand queue: {a, b, last} per entry.
    logic [16:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fifo_cnt;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  head_a;
    logic [7:0]  head_b;
    logic        head_last;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          last_seen;
    logic [7:0]    frame_cnt;
    logic [DW-1:0] drain_cnt;
    logic          stream_slot;
    logic          capture;

    // Occupancy comes from registered pointers only, so a pop in this
    // cycle cannot open a slot for a push in the same cycle.
    assign fifo_cnt = wr_ptr - rd_ptr;
    assign full     = (fifo_cnt == FULL_CNT);
    assign empty    = (fifo_cnt == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    assign {head_a, head_b, head_last} = fifo_mem[rd_ptr[AW-1:0]];

    // A pin slot exists on the CLEAR->STREAM edge and on every STREAM
    // edge until the last pair of the frame has been issued.
    assign stream_slot = (state == S_CLEAR) ||
                         ((state == S_STREAM) && !last_seen);
    assign pop         = stream_slot && !empty;

    assign busy    = (state != S_IDLE);
    assign capture = (state == S_DRAIN) && (state_nxt == S_DONE);

    // Next-state selection for the frame sequencer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (last_seen) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Queue storage and pointers; reset flushes any pending frame.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_last};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered accelerator pins; the clear is held high through reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mac_rst <= 1'b1;
            mac_a   <= '0;
            mac_b   <= '0;
        end else begin
            mac_rst <= (state_nxt == S_CLEAR);
            mac_a   <= pop ? head_a : 8'd0;
            mac_b   <= pop ? head_b : 8'd0;
        end
    end

    // Per-frame bookkeeping: pair count, last flag and drain timer.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            frame_cnt <= '0;
            last_seen <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (state_nxt == S_CLEAR) begin
                frame_cnt <= '0;
                last_seen <= 1'b0;
            end else if (pop) begin
                last_seen <= head_last;
                if (frame_cnt != 8'hFF) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            if ((state == S_STREAM) && (state_nxt == S_DRAIN)) begin
                drain_cnt <= DRAIN_INIT;
            end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    // Result capture at the end of DRAIN; held until the next frame.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
        end else begin
            res_valid <= capture;
            if (capture) begin
                res_data  <= mac_result;
                res_count <= frame_cnt;
            end
        end
    end

endmodule

// File: doc/mac_stream_driver.md
# mac_stream_driver

Host-side driver for the MAC accelerator's pin interface. It sits at the opposite end of the accelerator pins from the accelerator itself and plays the role the bench plays in simulation. It takes frames of 8-bit operand pairs over a valid/ready stream, buffers them, and clears the accelerator. It then streams the pairs onto the operand pins, waits out the accelerator latency, and returns the 8-bit accumulated result with a pair count.

## Interface
- `DEPTH`, default 4: operand FIFO entries (power of two, ≥2).
- `LAT`, default 1: accelerator cycles from absorbing a pair to showing it on its output pins (≥1).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset. Asynchronous and active-high despite the codebase name; clears every register immediately.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept a pair.
- `in_a` in 8: operand A.
- `in_b` in 8: operand B.
- `in_last` in 1: marks the final pair of a frame.
- `mac_rst` out 1: accelerator clear, active-high.
- `mac_a` out 8: drives the accelerator's `ui_in`.
- `mac_b` out 8: drives the accelerator's `uio_in`.
- `mac_result` in 8: the accelerator's `uo_out`.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out 8: captured result.
- `res_count` out 8: pairs in the frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Accelerator contract:**
  - `mac_rst`=1 at an edge zeroes the accumulator.
  - Otherwise each edge adds `mac_a`×`mac_b`.
  - `uo_out` = accumulator[7:0], visible `LAT` cycles after the absorbing edge.
  - A zero pair is a no-op bubble.
- **FIFO:** holds {a, b, last}.
  - `in_ready` = !full.
  - A push happens when `in_valid && in_ready`.
  - A pop never frees a slot for a same-cycle push.
  - Pushes are accepted in every state, so the next frame can queue during the current one.
- **FSM states:** IDLE, CLEAR, STREAM, DRAIN, DONE.
  - **IDLE:** `mac_a`/`mac_b`=0, `mac_rst`=0. Moves to CLEAR when the FIFO is non-empty.
  - **CLEAR:** `mac_rst`=1 for exactly one cycle, operands 0, count cleared. Moves to STREAM.
  - **STREAM, FIFO non-empty:** pop one entry, drive its a/b next cycle, count +1.
  - **STREAM, FIFO empty:** drive 0/0 (a bubble); no count change, no timeout.
  - **STREAM, popped entry has `last`=1:** move to DRAIN.
  - **DRAIN:** operands 0 for `LAT` cycles. At the edge ending DRAIN, `res_data` ← `mac_result`, `res_count` ← count.
  - **DONE:** `res_valid`=1 for one cycle. Moves to IDLE; the FIFO is re-checked next cycle.
- **Outputs:** `mac_a`, `mac_b` and `mac_rst` are registered, with no combinational path from FIFO or inputs.
- **Arithmetic:**
  - The result is the low byte of Σa·b, i.e. modulo 256. It is identical for signed and unsigned interpretation.
  - `res_count` saturates at 255, but pairs beyond 255 are still streamed.
  - `res_data` and `res_count` hold until the next capture.
- **Reset values:**
  - `mac_rst`=1, driven high during reset so the accelerator is held clear.
  - `mac_a`, `mac_b`, `res_valid`, `res_data`, `res_count`, `busy` = 0.
  - `in_ready`=1; FIFO empty; state IDLE.
- **Reset mid-frame:** the FIFO is flushed, the frame is discarded, and no `res_valid` is produced.
- **`in_last` on an empty frame:** impossible; a frame always contains at least its last pair.

## Timing
- Pair accepted at edge E0:
  - CLEAR (`mac_rst`=1) during E1–E2.
  - First pair on the pins during E2–E3.
- Back-to-back frame of N pairs with no bubbles:
  - The last pair is on the pins in cycle E(N+1).
  - DRAIN covers `LAT` cycles.
  - `res_valid` is high in cycle E(N+2+`LAT`), i.e. with `LAT`=1, 3+N edges after E0.
- Each bubble cycle adds one cycle of latency.
- Minimum gap between frames: `res_valid` cycle, then IDLE, then CLEAR. `mac_rst` never overlaps a non-zero operand.
- The first clock after reset release drives `mac_rst`=0 (IDLE).

## Test plan
- **Basic:** frame (3,4), (5,6, last) with the bench accelerator model (`LAT`=1) → `res_data`=42, `res_count`=2, `res_valid` 5 edges after the first accept, one cycle wide.
- **Wrap:** frame (16,16), (200,2, last) → 256+400=656, so `res_data`=0x90, `res_count`=2.
- **Bubbles:** pairs (1,1), gap 3 cycles, (2,2), gap 1 cycle, (3,3, last) → bubbles on the pins are 0/0, `res_data`=14, `res_count`=3, latency extended by 4 cycles.
- **Backpressure:** push 7 pairs while `mac_result` is unused → `in_ready` drops when 4 entries are queued. No pair is lost or duplicated, verified by `res_count`=7 and the sum check.
- **Back-to-back frames:** frame (2,3, last) then (4,5, last) pushed consecutively → results 6 then 20. `mac_rst` pulses once per frame, and the second result is unaffected by the first.
- **Reset mid-frame:** assert `rst_n` during STREAM of a 4-pair frame →
  - Asynchronously: `mac_rst`=1, `busy`=0, `res_valid`=0, FIFO empty.
  - A subsequent frame (7,7, last) then gives `res_data`=49.
